drum_grid_ctrl: RTL and testbench

- Parametrised iteration controller for the column-parallel drum (2D wave) solver.
- Launches one time-step on all NUM_COLS column engines with a one-cycle start pulse, then collects each column's iteration-complete flag.
- Samples the centre-node amplitude and computes the nonlinear tension rho_eff = min(RHO_MAX, rho_init + (u_c>>>CENTER_SHIFT)^2) for the next step.
- Reports per-iteration cycle count and a done pulse to the audio side.

---
 rtl/drum_pkg.sv | 40 ++++
 rtl/rho_update.sv | 48 ++++
 rtl/drum_grid_ctrl.sv | 148 ++++++++++++++
 tb/tb_drum_grid_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// ============================================================================
//  Module      : drum_pkg
//  Description : Shared fixed-point constants, controller state encoding and
//                the signed multiply helper for the drum grid solver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package drum_pkg;

    localparam int DATA_W    = 18;
    localparam int FRAC_BITS = DATA_W - 1;

    localparam logic signed [DATA_W-1:0] FP_ZERO    = '0;
    localparam logic signed [DATA_W-1:0] FP_RHO_MAX = 18'sh0FAE1;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_LAUNCH = 3'd1;
    localparam logic [ST_W-1:0] ST_RUN    = 3'd2;
    localparam logic [ST_W-1:0] ST_UPDATE = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE   = 3'd4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_RUN    = ST_RUN,
        S_UPDATE = ST_UPDATE,
        S_DONE   = ST_DONE
    } state_t;

    // Operands are sign-extended to 32 bits by the caller; valid for DATA_W <= 32.
    function automatic logic signed [63:0] signed_mult(input logic signed [31:0] a,
                                                       input logic signed [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rho_update.sv
// ============================================================================
//  Module      : rho_update
//  Description : Combinational core of the tension update: scaled square of
//                the centre amplitude and the clamped base + square sum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rho_update #(
    parameter int                        DATA_W       = drum_pkg::DATA_W,
    parameter int                        CENTER_SHIFT = 4,
    parameter logic signed [DATA_W-1:0]  RHO_MAX      = drum_pkg::FP_RHO_MAX
) (
    input  logic signed [DATA_W-1:0] i_u_center,
    input  logic signed [DATA_W-1:0] i_rho_base,
    input  logic signed [DATA_W-1:0] i_sq,
    output logic signed [DATA_W-1:0] o_sq,
    output logic signed [DATA_W-1:0] o_rho_sat
);
    import drum_pkg::*;

    localparam int c_frac_bits = DATA_W - 1;

    logic signed [DATA_W-1:0] w_a;
    logic signed [63:0]       w_prod;
    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W:0]   w_max_ext;

    assign w_a    = i_u_center >>> CENTER_SHIFT;
    assign w_prod = signed_mult(32'(w_a), 32'(w_a));
    // Product is a square, so the shifted result is non-negative and fits DATA_W.
    assign o_sq   = DATA_W'(w_prod >>> c_frac_bits);

    assign w_sum     = (DATA_W+1)'(i_rho_base) + (DATA_W+1)'(i_sq);
    assign w_max_ext = (DATA_W+1)'(RHO_MAX);

    always_comb begin
        o_rho_sat = w_sum[DATA_W-1:0];
        if (w_sum[DATA_W]) begin
            o_rho_sat = '0;
        end else if (w_sum >= w_max_ext) begin
            o_rho_sat = RHO_MAX;
        end
    end

endmodule

`default_nettype wire

// File: rtl/drum_grid_ctrl.sv
// ============================================================================
//  Module      : drum_grid_ctrl
//  Description : Iteration controller for the column-parallel drum solver.
//                Optional RUN watchdog enabled by macro DRUM_GRID_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module drum_grid_ctrl #(
    parameter int                        NUM_COLS       = 30,
    parameter int                        DATA_W         = drum_pkg::DATA_W,
    parameter int                        CENTER_SHIFT   = 4,
    parameter logic signed [DATA_W-1:0]  RHO_MAX        = drum_pkg::FP_RHO_MAX,
    parameter int                        TIMER_W        = 32,
    parameter int                        TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_50,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [DATA_W-1:0]  rho_init,
    input  logic [NUM_COLS-1:0]       col_flag,
    input  logic signed [DATA_W-1:0]  u_center_in,
    output logic                      col_start,
    output logic signed [DATA_W-1:0]  rho_eff,
    output logic signed [DATA_W-1:0]  u_center,
    output logic [TIMER_W-1:0]        timer_output,
    output logic [TIMER_W-1:0]        iter_count,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);
    import drum_pkg::*;

`ifdef DRUM_GRID_TIMEOUT_EN
    localparam bit c_wdog_en = 1'b1;
`else
    localparam bit c_wdog_en = 1'b0;
`endif

    state_t                    r_state;
    logic [NUM_COLS-1:0]       r_sticky;
    logic [TIMER_W-1:0]        r_run_cnt;
    logic signed [DATA_W-1:0]  r_sq;
    logic                      r_first_iter;
    logic                      r_timed_out;
    logic                      r_error;

    logic [NUM_COLS-1:0]       w_seen;
    logic                      w_all_seen;
    logic                      w_timeout_hit;
    logic signed [DATA_W-1:0]  w_sq_sel;
    logic signed [DATA_W-1:0]  w_sq;
    logic signed [DATA_W-1:0]  w_rho_sat;

    assign w_seen        = r_sticky | col_flag;
    assign w_all_seen    = &w_seen;
    assign w_timeout_hit = c_wdog_en && (r_run_cnt == TIMER_W'(TIMEOUT_CYCLES - 1));
    // In IDLE the clamp path is reused with a zero square to bound the first rho_init.
    assign w_sq_sel      = (r_state == S_IDLE) ? '0 : r_sq;
    assign error         = r_error;

    rho_update #(
        .DATA_W       (DATA_W),
        .CENTER_SHIFT (CENTER_SHIFT),
        .RHO_MAX      (RHO_MAX)
    ) u_rho_update (
        .i_u_center (u_center),
        .i_rho_base (rho_init),
        .i_sq       (w_sq_sel),
        .o_sq       (w_sq),
        .o_rho_sat  (w_rho_sat)
    );

    always_ff @(posedge clk_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sticky     <= '0;
            r_run_cnt    <= '0;
            r_sq         <= '0;
            r_first_iter <= 1'b1;
            r_timed_out  <= 1'b0;
            r_error      <= 1'b0;
            col_start    <= 1'b0;
            rho_eff      <= '0;
            u_center     <= '0;
            timer_output <= '0;
            iter_count   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            col_start <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LAUNCH;
                        col_start <= 1'b1;
                        busy      <= 1'b1;
                        if (r_first_iter) begin
                            rho_eff <= w_rho_sat;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_sticky    <= '0;
                    r_run_cnt   <= '0;
                    r_timed_out <= 1'b0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    r_run_cnt <= r_run_cnt + 1'b1;
                    r_sticky  <= w_seen;
                    if (w_all_seen) begin
                        u_center     <= u_center_in;
                        timer_output <= r_run_cnt + 1'b1;
                        r_state      <= S_UPDATE;
                    end else if (w_timeout_hit) begin
                        r_error     <= 1'b1;
                        r_timed_out <= 1'b1;
                        done        <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_UPDATE: begin
                    r_sq    <= w_sq;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!r_timed_out) begin
                        rho_eff      <= w_rho_sat;
                        iter_count   <= iter_count + 1'b1;
                        r_first_iter <= 1'b0;
                    end
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_drum_grid_ctrl.sv
// ============================================================================
//  Module      : tb_drum_grid_ctrl
//  Description : Self-checking bench for drum_grid_ctrl with a reference model
//                of the tension update and iteration timing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drum_grid_ctrl;

    localparam int NUM_COLS = 30;
    localparam int DATA_W   = 18;
    localparam int TIMER_W  = 32;
    localparam int RHO_MAX  = 'h0FAE1;

    logic                 clk_50 = 1'b0;
    logic                 reset  = 1'b1;
    logic                 start  = 1'b0;
    logic [DATA_W-1:0]    rho_init = '0;
    logic [NUM_COLS-1:0]  col_flag = '0;
    logic [DATA_W-1:0]    u_center_in = '0;
    logic                 col_start;
    logic [DATA_W-1:0]    rho_eff;
    logic [DATA_W-1:0]    u_center;
    logic [TIMER_W-1:0]   timer_output;
    logic [TIMER_W-1:0]   iter_count;
    logic                 busy;
    logic                 done;
    logic                 error;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int  exp_rho   = 0;
    int  exp_iter  = 0;
    bit  exp_first = 1'b1;

    drum_grid_ctrl #(
        .NUM_COLS       (NUM_COLS),
        .DATA_W         (DATA_W),
        .CENTER_SHIFT   (4),
        .RHO_MAX        (18'sh0FAE1),
        .TIMER_W        (TIMER_W),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .start        (start),
        .rho_init     (rho_init),
        .col_flag     (col_flag),
        .u_center_in  (u_center_in),
        .col_start    (col_start),
        .rho_eff      (rho_eff),
        .u_center     (u_center),
        .timer_output (timer_output),
        .iter_count   (iter_count),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk_50 = ~clk_50;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int to_signed(input logic [DATA_W-1:0] v);
        return (v >= (1 << (DATA_W-1))) ? int'(v) - (1 << DATA_W) : int'(v);
    endfunction

    function automatic int clamp_rho(input int s);
        if (s < 0) return 0;
        if (s >= RHO_MAX) return RHO_MAX;
        return s;
    endfunction

    // floor(u / 16) squared, scaled down by 2^17 (result non-negative)
    function automatic int square_term(input logic [DATA_W-1:0] u);
        int ui = to_signed(u);
        int a  = (ui >= 0) ? ui / 16 : -((-ui + 15) / 16);
        longint p = longint'(a) * longint'(a);
        return int'(p / 131072);
    endfunction

    task automatic run_iter(input logic [DATA_W-1:0] rho, input logic [DATA_W-1:0] u,
                            input int main_cyc, input int last_cyc,
                            input bit dup, input bit poke);
        int final_cyc = (main_cyc > last_cyc) ? main_cyc : last_cyc;
        int done_seen = 0;
        int done_at   = -1;
        int cs_seen   = 0;
        rho_init    = rho;
        u_center_in = u;
        start       = 1'b1;
        tick();
        check("col_start_latency", col_start, 1);
        check("busy_after_start", busy, 1);
        if (exp_first) exp_rho = clamp_rho(to_signed(rho));
        check("rho_eff_at_launch", rho_eff, exp_rho);
        start = 1'b0;
        tick();
        check("col_start_one_cycle", col_start, 0);
        for (int cyc = 1; cyc <= final_cyc + 4; cyc++) begin
            col_flag = '0;
            if (cyc == main_cyc) col_flag[NUM_COLS-2:0] = '1;
            if (dup && cyc == main_cyc + 2) col_flag[3] = 1'b1;
            if (cyc == last_cyc) col_flag[NUM_COLS-1] = 1'b1;
            start = poke && (cyc == 3);
            tick();
            if (done) begin
                done_seen++;
                if (done_at < 0) done_at = cyc;
            end
            cs_seen += int'(col_start);
        end
        col_flag = '0;
        start    = 1'b0;
        exp_rho   = clamp_rho(to_signed(rho) + square_term(u));
        exp_iter  = exp_iter + 1;
        exp_first = 1'b0;
        check("done_count", done_seen, 1);
        check("done_latency", done_at, final_cyc + 1);
        check("no_relaunch", cs_seen, 0);
        check("busy_idle", busy, 0);
        check("timer_output", timer_output, final_cyc);
        check("u_center", u_center, u);
        check("rho_eff", rho_eff, exp_rho);
        check("iter_count", iter_count, exp_iter);
        check("error_clear", error, 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        check("rst_col_start", col_start, 0);
        check("rst_rho_eff", rho_eff, 0);
        check("rst_u_center", u_center, 0);
        check("rst_timer", timer_output, 0);
        check("rst_iter", iter_count, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset = 1'b0;
        tick();

        run_iter(18'h02000, 18'h00000, 10, 10, 1'b0, 1'b0);
        run_iter(18'h02000, 18'h10000, 7, 7, 1'b0, 1'b0);
        check("sq_half_amplitude", rho_eff, 'h02080);
        run_iter(18'h0FA00, 18'h1FFFF, 8, 8, 1'b0, 1'b0);
        check("clamp_rho_max", rho_eff, 'h0FAE1);
        run_iter(18'h01000, 18'h30000, 5, 20, 1'b1, 1'b0);
        run_iter(18'h3F000, 18'h08000, 6, 6, 1'b0, 1'b1);
        check("clamp_zero", rho_eff, 0);

        for (int k = 0; k < 8; k++) begin
            int m = int'($urandom_range(1, 15));
            int l = int'($urandom_range(1, 15));
            int f = (m > l) ? m : l;
            run_iter(DATA_W'($urandom), DATA_W'($urandom), m, l,
                     1'($urandom), (f >= 4) ? 1'($urandom) : 1'b0);
        end

        // Reset in the middle of RUN
        start = 1'b1;
        rho_init = 18'h02000;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_col_start", col_start, 0);
        check("midrst_timer", timer_output, 0);
        check("midrst_iter", iter_count, 0);
        check("midrst_rho", rho_eff, 0);
        reset = 1'b0;
        tick();
        exp_rho = 0;
        exp_iter = 0;
        exp_first = 1'b1;
        run_iter(18'h1F000, 18'h00000, 4, 9, 1'b0, 1'b0);

`ifdef DRUM_GRID_TIMEOUT_EN
        begin
            int done_seen = 0;
            int done_at   = -1;
            rho_init    = 18'h00100;
            u_center_in = 18'h12345;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            for (int cyc = 1; cyc <= 80; cyc++) begin
                col_flag = '0;
                if (cyc == 2) begin
                    col_flag = '1;
                    col_flag[7] = 1'b0;
                end
                tick();
                if (done) begin
                    done_seen++;
                    if (done_at < 0) done_at = cyc;
                end
            end
            col_flag = '0;
            check("wdog_error", error, 1);
            check("wdog_done_count", done_seen, 1);
            check("wdog_done_at", done_at, 64);
            check("wdog_rho_kept", rho_eff, exp_rho);
            check("wdog_iter_kept", iter_count, exp_iter);
            check("wdog_busy", busy, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
